credit_return_fifo: RTL and testbench

CREDIT_RETURN_FIFO -- requirements
Module: credit_return_fifo

---
 rtl/credit_return_fifo.sv | 92 +++++++++
 tb/tb_credit_return_fifo.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/credit_return_fifo.sv
// Buffering FIFO that coalesces pop-side credits into batched returns for a downstream
// credit counter, flushing partial batches after an idle timeout.
module credit_return_fifo #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned CREDIT_W = 10,
    parameter int unsigned BATCH    = 4,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    enq__ENA,
    input  logic [DATA_W-1:0]       enq_v,
    output logic                    enq__RDY,
    input  logic                    deq__ENA,
    output logic [DATA_W-1:0]       deq,
    output logic                    deq__RDY,
    output logic                    credit__ENA,
    output logic [CREDIT_W-1:0]     credit_v,
    input  logic                    credit__RDY,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [AW-1:0]       wptr_q, wptr_d;
    logic [AW-1:0]       rptr_q, rptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [CREDIT_W-1:0] pend_q, pend_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                ovf_q, ovf_d;
    logic                push, pop, fire;

    always_comb begin
        enq__RDY    = (count_q != CW'(DEPTH)) && !RST;
        deq__RDY    = (count_q != '0) && !RST;
        push        = enq__ENA && enq__RDY;
        pop         = deq__ENA && deq__RDY;
        fire        = (pend_q >= CREDIT_W'(BATCH)) ||
                      ((pend_q != '0) && (timer_q == TW'(TIMEOUT)));
        credit__ENA = fire && credit__RDY && !RST;
        credit_v    = pend_q;
        deq         = mem_q[rptr_q];
        count       = count_q;
        overflow    = ovf_q;
    end

    always_comb begin
        // Pointers wrap for free because DEPTH is a power of two.
        wptr_d  = wptr_q + AW'(push);
        rptr_d  = rptr_q + AW'(pop);
        count_d = count_q + CW'(push) - CW'(pop);
        pend_d  = credit__ENA ? CREDIT_W'(pop) : pend_q + CREDIT_W'(pop);
        timer_d = timer_q;
        if (credit__ENA || (pend_q == '0)) begin
            timer_d = '0;
        end else if (timer_q != TW'(TIMEOUT)) begin
            timer_d = timer_q + TW'(1);
        end
        ovf_d = ovf_q | (enq__ENA && !enq__RDY && !RST);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            pend_q  <= '0;
            timer_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            timer_q <= timer_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage is never reset; push is already gated off during reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wptr_q] <= enq_v;
        end
    end

endmodule

// File: tb/tb_credit_return_fifo.sv
// Bench for credit_return_fifo: directed scenarios plus random traffic, all checked
// against a queue-based reference model of occupancy, pending credits and idle time.
module tb_credit_return_fifo;

    localparam int DEPTH   = 8;
    localparam int BATCH   = 4;
    localparam int TIMEOUT = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        enq__ENA;
    logic [31:0] enq_v;
    logic        enq__RDY;
    logic        deq__ENA;
    logic [31:0] deq;
    logic        deq__RDY;
    logic        credit__ENA;
    logic [9:0]  credit_v;
    logic        credit__RDY;
    logic [3:0]  count;
    logic        overflow;

    credit_return_fifo dut (
        .CLK         (CLK),
        .RST         (RST),
        .enq__ENA    (enq__ENA),
        .enq_v       (enq_v),
        .enq__RDY    (enq__RDY),
        .deq__ENA    (deq__ENA),
        .deq         (deq),
        .deq__RDY    (deq__RDY),
        .credit__ENA (credit__ENA),
        .credit_v    (credit_v),
        .credit__RDY (credit__RDY),
        .count       (count),
        .overflow    (overflow)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_q[$];
    int          m_pend = 0;
    int          m_timer = 0;
    bit          m_ovf = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, compare every output to the model, then advance the model.
    task automatic cycle(input bit e, input logic [31:0] d, input bit q, input bit cr,
                         input bit r);
        bit exp_erdy, exp_drdy, exp_fire, exp_cena, push, pop;
        @(negedge CLK);
        enq__ENA = e; enq_v = d; deq__ENA = q; credit__RDY = cr; RST = r;
        #1;
        exp_erdy = !r && (m_q.size() != DEPTH);
        exp_drdy = !r && (m_q.size() != 0);
        exp_fire = (m_pend >= BATCH) || (m_pend != 0 && m_timer == TIMEOUT);
        exp_cena = !r && exp_fire && cr;
        check("enq_rdy", 64'(enq__RDY), 64'(exp_erdy));
        check("deq_rdy", 64'(deq__RDY), 64'(exp_drdy));
        check("count", 64'(count), 64'(m_q.size()));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("credit_ena", 64'(credit__ENA), 64'(exp_cena));
        check("credit_v", 64'(credit_v), 64'(m_pend));
        if (exp_drdy) check("deq_data", 64'(deq), 64'(m_q[0]));
        if (r) begin
            m_q.delete();
            m_pend = 0; m_timer = 0; m_ovf = 1'b0;
        end else begin
            push = e && exp_erdy;
            pop  = q && exp_drdy;
            if (e && !exp_erdy) m_ovf = 1'b1;
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(d);
            if (exp_cena || m_pend == 0) m_timer = 0;
            else if (m_timer < TIMEOUT) m_timer++;
            m_pend = exp_cena ? int'(pop) : m_pend + int'(pop);
        end
    endtask

    initial begin
        int pulses;
        RST = 1'b1; enq__ENA = 0; enq_v = '0; deq__ENA = 0; credit__RDY = 1;
        repeat (2) cycle(0, 0, 0, 1, 1);

        // Fill and drain
        for (int i = 0; i < 8; i++) cycle(1, 32'h11 + 32'(i), 0, 1, 0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 1, 1, 0);
            if (i == 0) begin
                check("full_count", 64'(count), 64'd8);
                check("full_enq_rdy", 64'(enq__RDY), 64'd0);
            end
            check("drain_order", 64'(deq), 64'h11 + 64'(i));
            if (credit__ENA) pulses++;
            if (i == 4) check("batch1_v", 64'({credit__ENA, credit_v}), 64'h404);
        end
        cycle(0, 0, 0, 1, 0);
        check("batch2_v", 64'({credit__ENA, credit_v}), 64'h404);
        if (credit__ENA) pulses++;
        check("batch_pulses", 64'(pulses), 64'd2);

        // Timeout flush
        cycle(1, 32'hA5, 0, 1, 0);
        cycle(0, 0, 1, 1, 0);
        for (int j = 0; j <= TIMEOUT; j++) begin
            cycle(0, 0, 0, 1, 0);
            check("timeout_ena", 64'(credit__ENA), 64'(j == TIMEOUT));
        end
        check("timeout_v", 64'(credit_v), 64'd1);
        cycle(0, 0, 0, 1, 0);
        check("timeout_pend0", 64'(credit_v), 64'd0);

        // Backpressure
        for (int i = 0; i < 6; i++) cycle(1, 32'h100 + 32'(i), 0, 1, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check("bp_held", 64'({credit__ENA, credit_v}), 64'h006);
        cycle(0, 0, 0, 1, 0);
        check("bp_release", 64'({credit__ENA, credit_v}), 64'h406);
        cycle(0, 0, 0, 1, 0);
        check("bp_after", 64'({credit__ENA, credit_v}), 64'h000);

        // Full plus simultaneous enqueue and pop
        for (int i = 0; i < 8; i++) cycle(1, 32'h200 + 32'(i), 0, 1, 0);
        cycle(1, 32'hDEAD, 1, 1, 0);
        check("full_both_pre", 64'(count), 64'd8);
        cycle(1, 32'hBEEF, 1, 1, 0);
        check("full_both_cnt", 64'(count), 64'd7);
        check("full_both_ovf", 64'(overflow), 64'd1);
        cycle(0, 0, 0, 1, 0);
        check("seven_both_cnt", 64'(count), 64'd7);
        check("seven_both_ovf", 64'(overflow), 64'd1);

        // Reset mid-operation with count=5, pend=3
        cycle(0, 0, 0, 1, 1);
        for (int i = 0; i < 8; i++) cycle(1, 32'h300 + 32'(i), 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 0);
        cycle(1, 32'h1, 0, 1, 0);
        check("pre_rst_cnt", 64'(count), 64'd5);
        check("pre_rst_pend", 64'(credit_v), 64'd3);
        cycle(0, 0, 0, 1, 1);
        check("rst_no_credit", 64'(credit__ENA), 64'd0);
        cycle(1, 32'h77, 0, 1, 0);
        check("post_rst", 64'({enq__RDY, count, credit_v, overflow, credit__ENA}),
              64'({1'b1, 4'd0, 10'd0, 1'b0, 1'b0}));
        cycle(0, 0, 1, 1, 0);
        check("post_rst_data", 64'(deq), 64'h77);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            cycle(1'($urandom_range(0, 99) < 55), $urandom, 1'($urandom_range(0, 99) < 45),
                  1'($urandom_range(0, 99) < 80), 1'($urandom_range(0, 199) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
